// File: rtl/calendar_date_counter.sv
// Day-of-year / month / day counter with inc/dec stepping, year wrap, optional leap handling,
// a multi-cycle binary day-of-year load and active-low seven-segment outputs.
module calendar_date_counter #(
  parameter bit LEAP_EN       = 1'b1,
  parameter bit BLANK_LEADING = 1'b1,
  parameter int DOY_W         = 9
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  input  logic             dec,
  input  logic             leap,
  input  logic             load_valid,
  input  logic [DOY_W-1:0] load_doy,
  output logic             load_ready,
  output logic             load_done,
  output logic             load_err,
  output logic             busy,
  output logic [DOY_W-1:0] doy,
  output logic [7:0]       month_bcd,
  output logic [7:0]       day_bcd,
  output logic [7:0]       seg_mon_t,
  output logic [7:0]       seg_mon_o,
  output logic [7:0]       seg_day_t,
  output logic [7:0]       seg_day_o
);

  // Load handshake: a load transfers on a rising edge where load_valid && load_ready;
  // load_ready is high exactly in IDLE, and load_done pulses one cycle after commit or reject.
  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] CONVERT = 1'b1;

  localparam logic [DOY_W-1:0] DAYS365 = DOY_W'(365);
  localparam logic [DOY_W-1:0] DOY_ONE = DOY_W'(1);

  logic [0:0]       state_q, state_d;
  logic [3:0]       month_q, month_d;
  logic [4:0]       day_q, day_d;
  logic [DOY_W-1:0] doy_q, doy_d;
  logic             leap_q, leap_d;
  logic [DOY_W-1:0] rem_q, rem_d;
  logic [3:0]       m_q, m_d;
  logic [DOY_W-1:0] ld_doy_q, ld_doy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic             leap_eff;
  logic [DOY_W-1:0] year_len_eff;
  logic [4:0]       cur_len;
  logic [4:0]       conv_len;

  function automatic logic [4:0] month_len(input logic [3:0] m, input logic lp);
    case (m)
      4'd2:                      month_len = lp ? 5'd29 : 5'd28;
      4'd4, 4'd6, 4'd9, 4'd11:   month_len = 5'd30;
      default:                   month_len = 5'd31;
    endcase
  endfunction

  function automatic logic [7:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 8'hC0;
      4'd1:    seg7 = 8'hF9;
      4'd2:    seg7 = 8'hA4;
      4'd3:    seg7 = 8'hB0;
      4'd4:    seg7 = 8'h99;
      4'd5:    seg7 = 8'h92;
      4'd6:    seg7 = 8'h82;
      4'd7:    seg7 = 8'hF8;
      4'd8:    seg7 = 8'h80;
      4'd9:    seg7 = 8'h90;
      default: seg7 = 8'hFF;
    endcase
  endfunction

  assign leap_eff     = leap && LEAP_EN;
  assign year_len_eff = DAYS365 + {{(DOY_W-1){1'b0}}, leap_eff};
  assign cur_len      = month_len(month_q, leap_q);
  assign conv_len     = month_len(m_q, leap_q);

  always_comb begin
    state_d  = state_q;
    month_d  = month_q;
    day_d    = day_q;
    doy_d    = doy_q;
    leap_d   = leap_q;
    rem_d    = rem_q;
    m_d      = m_q;
    ld_doy_d = ld_doy_q;
    done_d   = 1'b0;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (load_valid) begin
          if (load_doy == '0 || load_doy > year_len_eff) begin
            err_d  = 1'b1;
            done_d = 1'b1;
          end else begin
            rem_d    = load_doy;
            m_d      = 4'd1;
            leap_d   = leap_eff;
            ld_doy_d = load_doy;
            state_d  = CONVERT;
          end
        end else if (inc && !dec) begin
          if (day_q == cur_len) begin
            day_d = 5'd1;
            if (month_q == 4'd12) begin
              month_d = 4'd1;
              doy_d   = DOY_ONE;
              leap_d  = leap_eff;
            end else begin
              month_d = month_q + 4'd1;
              doy_d   = doy_q + DOY_ONE;
            end
          end else begin
            day_d = day_q + 5'd1;
            doy_d = doy_q + DOY_ONE;
          end
        end else if (dec && !inc) begin
          if (day_q == 5'd1) begin
            if (month_q == 4'd1) begin
              // Year wrap backwards: the new year's leap flag decides doy.
              month_d = 4'd12;
              day_d   = 5'd31;
              leap_d  = leap_eff;
              doy_d   = year_len_eff;
            end else begin
              month_d = month_q - 4'd1;
              day_d   = month_len(month_q - 4'd1, leap_q);
              doy_d   = doy_q - DOY_ONE;
            end
          end else begin
            day_d = day_q - 5'd1;
            doy_d = doy_q - DOY_ONE;
          end
        end
      end
      CONVERT: begin
        if (rem_q > {{(DOY_W-5){1'b0}}, conv_len}) begin
          rem_d = rem_q - {{(DOY_W-5){1'b0}}, conv_len};
          m_d   = m_q + 4'd1;
        end else begin
          month_d = m_q;
          day_d   = rem_q[4:0];
          doy_d   = ld_doy_q;
          err_d   = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      month_q  <= 4'd1;
      day_q    <= 5'd1;
      doy_q    <= DOY_ONE;
      leap_q   <= 1'b0;
      rem_q    <= '0;
      m_q      <= 4'd1;
      ld_doy_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      month_q  <= month_d;
      day_q    <= day_d;
      doy_q    <= doy_d;
      leap_q   <= leap_d;
      rem_q    <= rem_d;
      m_q      <= m_d;
      ld_doy_q <= ld_doy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  logic [3:0] mon_tens, mon_ones, day_tens, day_ones;

  always_comb begin
    mon_tens = (month_q >= 4'd10) ? 4'd1 : 4'd0;
    mon_ones = (month_q >= 4'd10) ? month_q - 4'd10 : month_q;
    if (day_q >= 5'd30) begin
      day_tens = 4'd3;
      day_ones = 4'(day_q - 5'd30);
    end else if (day_q >= 5'd20) begin
      day_tens = 4'd2;
      day_ones = 4'(day_q - 5'd20);
    end else if (day_q >= 5'd10) begin
      day_tens = 4'd1;
      day_ones = 4'(day_q - 5'd10);
    end else begin
      day_tens = 4'd0;
      day_ones = day_q[3:0];
    end
  end

  assign load_ready = (state_q == IDLE);
  assign busy       = (state_q == CONVERT);
  assign load_done  = done_q;
  assign load_err   = err_q;
  assign doy        = doy_q;
  assign month_bcd  = {mon_tens, mon_ones};
  assign day_bcd    = {day_tens, day_ones};
  assign seg_mon_t  = (BLANK_LEADING && mon_tens == 4'd0) ? 8'hFF : seg7(mon_tens);
  assign seg_mon_o  = seg7(mon_ones);
  assign seg_day_t  = (BLANK_LEADING && day_tens == 4'd0) ? 8'hFF : seg7(day_tens);
  assign seg_day_o  = seg7(day_ones);

endmodule

// File: tb/tb_calendar_date_counter.sv
// Directed bench for calendar_date_counter: stepping, wraps, multi-cycle loads, rejects and reset abort.
module tb_calendar_date_counter;

  logic       clk;
  logic       reset_n;
  logic       inc, dec, leap, load_valid;
  logic [8:0] load_doy;
  logic       load_ready, load_done, load_err, busy;
  logic [8:0] doy;
  logic [7:0] month_bcd, day_bcd, seg_mon_t, seg_mon_o, seg_day_t, seg_day_o;

  logic       d2_load_ready, d2_load_done, d2_load_err, d2_busy;
  logic [8:0] d2_doy;
  logic [7:0] d2_month_bcd, d2_day_bcd, d2_seg_mon_t, d2_seg_mon_o, d2_seg_day_t, d2_seg_day_o;

  int checks = 0;
  int errors = 0;

  calendar_date_counter #(.LEAP_EN(1'b1), .BLANK_LEADING(1'b1), .DOY_W(9)) dut (
    .clk(clk), .reset_n(reset_n), .inc(inc), .dec(dec), .leap(leap),
    .load_valid(load_valid), .load_doy(load_doy), .load_ready(load_ready),
    .load_done(load_done), .load_err(load_err), .busy(busy), .doy(doy),
    .month_bcd(month_bcd), .day_bcd(day_bcd), .seg_mon_t(seg_mon_t),
    .seg_mon_o(seg_mon_o), .seg_day_t(seg_day_t), .seg_day_o(seg_day_o)
  );

  calendar_date_counter #(.LEAP_EN(1'b1), .BLANK_LEADING(1'b0), .DOY_W(9)) dut2 (
    .clk(clk), .reset_n(reset_n), .inc(inc), .dec(dec), .leap(leap),
    .load_valid(load_valid), .load_doy(load_doy), .load_ready(d2_load_ready),
    .load_done(d2_load_done), .load_err(d2_load_err), .busy(d2_busy), .doy(d2_doy),
    .month_bcd(d2_month_bcd), .day_bcd(d2_day_bcd), .seg_mon_t(d2_seg_mon_t),
    .seg_mon_o(d2_seg_mon_o), .seg_day_t(d2_seg_day_t), .seg_day_o(d2_seg_day_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic step_inc(input int n);
    inc = 1'b1;
    repeat (n) tick();
    inc = 1'b0;
  endtask

  task automatic step_dec(input int n);
    dec = 1'b1;
    repeat (n) tick();
    dec = 1'b0;
  endtask

  // Presents one load, then watches a bounded window counting busy cycles and load_done pulses.
  task automatic do_load(input logic [8:0] v, input logic hold_inc, output int bc, output int dp,
                         output logic lr, output logic [7:0] hm, output logic [7:0] hd);
    load_valid = 1'b1;
    load_doy   = v;
    inc        = hold_inc;
    tick();
    load_valid = 1'b0;
    lr = load_ready;
    hm = month_bcd;
    hd = day_bcd;
    bc = 0;
    dp = 0;
    for (int i = 0; i < 16; i++) begin
      if (busy) bc++;
      if (load_done) dp++;
      inc = hold_inc & busy;
      tick();
    end
    inc = 1'b0;
  endtask

  // driver / stimulus
  initial begin
    int bc, dp;
    logic lr;
    logic [7:0] hm, hd;

    reset_n = 1'b0; inc = 1'b0; dec = 1'b0; leap = 1'b0;
    load_valid = 1'b0; load_doy = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_doy", doy, 1);
    check("rst_month", month_bcd, 8'h01);
    check("rst_day", day_bcd, 8'h01);
    check("rst_seg_mon_o", seg_mon_o, 8'hF9);
    check("rst_seg_day_o", seg_day_o, 8'hF9);
    check("rst_seg_mon_t", seg_mon_t, 8'hFF);
    check("rst_seg_day_t", seg_day_t, 8'hFF);
    check("rst_d2_seg_mon_t", d2_seg_mon_t, 8'hC0);
    check("rst_d2_seg_day_t", d2_seg_day_t, 8'hC0);
    check("rst_ready", load_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", load_done, 0);
    check("rst_err", load_err, 0);
    reset_n = 1'b1;
    tick();

    step_inc(4);
    check("jan5_day", day_bcd, 8'h05);
    check("jan5_seg_day_o", seg_day_o, 8'h92);
    check("jan5_seg_day_t", seg_day_t, 8'hFF);
    check("jan5_d2_seg_day_t", d2_seg_day_t, 8'hC0);

    step_inc(27);
    check("inc31_month", month_bcd, 8'h02);
    check("inc31_day", day_bcd, 8'h01);
    check("inc31_doy", doy, 32);
    check("inc31_seg_mon_t", seg_mon_t, 8'hFF);
    check("inc31_seg_mon_o", seg_mon_o, 8'hA4);

    leap = 1'b1;
    do_load(9'd60, 1'b0, bc, dp, lr, hm, hd);
    check("l60L_ready_low", lr, 0);
    check("l60L_hold_month", hm, 8'h02);
    check("l60L_hold_day", hd, 8'h01);
    check("l60L_busy_cycles", bc, 2);
    check("l60L_done_pulses", dp, 1);
    check("l60L_month", month_bcd, 8'h02);
    check("l60L_day", day_bcd, 8'h29);
    check("l60L_doy", doy, 60);

    leap = 1'b0;
    do_load(9'd60, 1'b0, bc, dp, lr, hm, hd);
    check("l60_busy_cycles", bc, 3);
    check("l60_done_pulses", dp, 1);
    check("l60_month", month_bcd, 8'h03);
    check("l60_day", day_bcd, 8'h01);

    do_load(9'd365, 1'b0, bc, dp, lr, hm, hd);
    check("l365_busy_cycles", bc, 12);
    check("l365_month", month_bcd, 8'h12);
    check("l365_day", day_bcd, 8'h31);
    check("l365_doy", doy, 365);
    check("l365_seg_mon_t", seg_mon_t, 8'hF9);
    check("l365_seg_day_t", seg_day_t, 8'hB0);
    step_inc(1);
    check("wrapf_month", month_bcd, 8'h01);
    check("wrapf_day", day_bcd, 8'h01);
    check("wrapf_doy", doy, 1);
    step_dec(1);
    check("wrapb_month", month_bcd, 8'h12);
    check("wrapb_day", day_bcd, 8'h31);
    check("wrapb_doy", doy, 365);
    step_inc(1);
    leap = 1'b1;
    step_dec(1);
    check("wrapbL_doy", doy, 366);
    check("wrapbL_day", day_bcd, 8'h31);

    leap = 1'b0;
    do_load(9'd0, 1'b0, bc, dp, lr, hm, hd);
    check("l0_ready", lr, 1);
    check("l0_busy_cycles", bc, 0);
    check("l0_done_pulses", dp, 1);
    check("l0_err", load_err, 1);
    check("l0_doy", doy, 366);
    do_load(9'd366, 1'b0, bc, dp, lr, hm, hd);
    check("l366_ready", lr, 1);
    check("l366_done_pulses", dp, 1);
    check("l366_err", load_err, 1);
    check("l366_month", month_bcd, 8'h12);
    check("l366_day", day_bcd, 8'h31);

    do_load(9'd100, 1'b0, bc, dp, lr, hm, hd);
    check("l100_busy_cycles", bc, 4);
    check("l100_month", month_bcd, 8'h04);
    check("l100_day", day_bcd, 8'h10);
    check("l100_err", load_err, 0);

    inc = 1'b1; dec = 1'b1;
    repeat (3) tick();
    inc = 1'b0; dec = 1'b0;
    check("incdec_day", day_bcd, 8'h10);
    check("incdec_doy", doy, 100);

    do_load(9'd200, 1'b1, bc, dp, lr, hm, hd);
    check("l200inc_busy_cycles", bc, 7);
    check("l200inc_month", month_bcd, 8'h07);
    check("l200inc_day", day_bcd, 8'h19);
    check("l200inc_doy", doy, 200);

    do_load(9'd61, 1'b0, bc, dp, lr, hm, hd);
    check("l61_day", day_bcd, 8'h02);
    step_dec(2);
    check("decm_month", month_bcd, 8'h02);
    check("decm_day", day_bcd, 8'h28);
    check("decm_doy", doy, 59);

    load_valid = 1'b1; load_doy = 9'd300;
    tick();
    load_valid = 1'b0;
    tick();
    tick();
    check("abort_busy_before", busy, 1);
    reset_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_month", month_bcd, 8'h01);
    check("abort_day", day_bcd, 8'h01);
    check("abort_doy", doy, 1);
    dp = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (load_done) dp++;
    end
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (load_done) dp++;
    end
    check("abort_no_done", dp, 0);
    check("abort_ready", load_ready, 1);
    check("abort_month_after", month_bcd, 8'h01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/calendar_date_counter.md
Name: calendar_date_counter

Overview:
Parametrised calendar day counter for the seven-segment date display path. It holds a consistent day-of-year / month / day triple and steps it forward or backward one day at a time, wrapping at year end, with optional leap-year handling. It also accepts a binary day-of-year load, converts it to month/day over several cycles under a ready/valid handshake, and drives active-low seven-segment codes for month and day digits directly.

Parameters:
LEAP_EN, 1, 1 = honour leap input (Feb 29, 366-day year); 0 = leap input ignored, always 365 days
BLANK_LEADING, 1, 1 = month tens and day tens segments blank (8'hFF) when the digit is 0; 0 = show "0"
DOY_W, 9, width of the binary day-of-year load and output (minimum 9)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
inc  in  1  advance one day (sampled on the rising clk edge, level = one step per cycle)
dec  in  1  go back one day
leap  in  1  current year is a leap year
load_valid  in  1  load request
load_doy  in  DOY_W  binary day-of-year to load (1-based)
load_ready  out  1  high in IDLE; load accepted when load_valid && load_ready
load_done  out  1  one-cycle pulse when a load commits or is rejected
load_err  out  1  sticky; set on out-of-range load, cleared by next accepted in-range load or reset
busy  out  1  high in CONVERT
doy  out  DOY_W  current day-of-year, binary
month_bcd  out  8  [7:4] tens, [3:0] ones
day_bcd  out  8  [7:4] tens, [3:0] ones
seg_mon_t, seg_mon_o, seg_day_t, seg_day_o  out  8 each  active-low segments, bit 7 = DP (always 1), bits 6:0 = g..a, 0 = 8'hC0 ... 9 = 8'h90

Behaviour:
- Reset (async, reset_n low): state IDLE, date Jan 1, doy=1, leap_q=0, load_ready=1, busy=0, load_done=0, load_err=0, month_bcd=8'h01, day_bcd=8'h01, seg_mon_o=seg_day_o=8'hF9, tens=8'hFF (BLANK_LEADING=1) or 8'hC0.
- leap_q (effective leap = leap && LEAP_EN) is latched only at load acceptance and on any year wrap (Dec 31->Jan 1 or Jan 1->Dec 31). Month lengths: 31,28+leap_q,31,30,31,30,31,31,30,31,30,31. Year length 365+leap_q.
- States: IDLE, CONVERT.
- IDLE, inc && !dec: next day, one-cycle latency. Day rolls to 1 and month increments at month end. Dec 31 -> Jan 1, doy -> 1, relatch leap_q.
- IDLE, dec && !inc: previous day. Day 1 -> last day of previous month. Jan 1 -> Dec 31, relatch leap_q first, doy = 365+leap_q.
- inc && dec together: no change. Both are ignored in CONVERT. Load acceptance has priority over inc/dec in the same cycle, and the step is dropped.
- Load accept (IDLE, load_valid): if load_doy==0 or load_doy > 365+leap_eff: no state change, load_err=1, load_done pulses next cycle, stay IDLE. Otherwise latch rem=load_doy, m=1, leap_q, go CONVERT, load_ready=0, busy=1.
- CONVERT, each cycle: if rem > len(m): rem -= len(m), m++. Else commit month=m, day=rem, doy=load_doy, load_err=0, state IDLE, and load_done pulses in the following cycle. Latency from accept edge to commit edge = (m_final - 1) + 1 cycles (1..12). Displayed date holds its old value until commit.
- Reset during CONVERT aborts the load to the reset state. No load_done.
- BCD and segment outputs are combinational from registered month/day. Codes outside 0..9 never occur.

Test Plan:
- Reset then 31 inc pulses -> month_bcd=8'h02, day_bcd=8'h01, doy=32, seg_mon_t=8'hFF, seg_mon_o=8'hA4.
- leap=1, load_doy=60 -> load_ready low, busy high for 2 cycles, commit Feb 29 (8'h02/8'h29), load_done single pulse. Same with leap=0 -> Mar 1.
- leap=0, load 365 -> busy 12 cycles, Dec 31, doy=365. One inc -> Jan 1, doy=1. One dec -> Dec 31, doy=365 (366 if leap driven 1 before wrap).
- Out-of-range loads 0 and 366 (leap=0) -> date unchanged, load_err=1, load_done pulses, load_ready stays 1. A subsequent load of 100 -> Apr 10, load_err=0.
- inc and dec asserted together, and inc asserted during CONVERT -> no date change. Load with inc in the same cycle -> load wins, no step applied.
- reset_n low mid-CONVERT (load 300) -> immediate Jan 1, busy=0, no load_done. BLANK_LEADING=0 instance shows seg_day_t=8'hC0 on day 5.
